// File: rtl/hyperbus_tf_arbiter.sv
// Round-robin whole-transfer arbiter sharing one HyperBus PHY transfer/TX/RX/B port among NumPorts front-ends.
// Optional watchdog abort is enabled with `define HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_tf_arbiter #(
  parameter int NumPorts      = 2,
  parameter int TransWidth    = 64,
  parameter int TxWidth       = 35,
  parameter int RxDataWidth   = 32,
  parameter int TimeoutCycles = 1024,
  localparam int IdxW         = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0][TransWidth-1:0]  port_trans_i,
  input  logic [NumPorts-1:0]                  port_trans_write_i,
  input  logic [NumPorts-1:0]                  port_trans_valid_i,
  output logic [NumPorts-1:0]                  port_trans_ready_o,
  input  logic [NumPorts-1:0][TxWidth-1:0]     port_tx_i,
  input  logic [NumPorts-1:0]                  port_tx_valid_i,
  output logic [NumPorts-1:0]                  port_tx_ready_o,
  output logic [RxDataWidth-1:0]               port_rx_data_o,
  output logic                                 port_rx_last_o,
  output logic                                 port_rx_error_o,
  output logic [NumPorts-1:0]                  port_rx_valid_o,
  input  logic [NumPorts-1:0]                  port_rx_ready_i,
  output logic                                 port_b_error_o,
  output logic [NumPorts-1:0]                  port_b_valid_o,
  input  logic [NumPorts-1:0]                  port_b_ready_i,
  output logic [TransWidth-1:0]                phy_trans_o,
  output logic                                 phy_trans_valid_o,
  input  logic                                 phy_trans_ready_i,
  output logic [TxWidth-1:0]                   phy_tx_o,
  output logic                                 phy_tx_valid_o,
  input  logic                                 phy_tx_ready_i,
  input  logic [RxDataWidth-1:0]               phy_rx_data_i,
  input  logic                                 phy_rx_last_i,
  input  logic                                 phy_rx_error_i,
  input  logic                                 phy_rx_valid_i,
  output logic                                 phy_rx_ready_o,
  input  logic                                 phy_b_error_i,
  input  logic                                 phy_b_valid_i,
  output logic                                 phy_b_ready_o,
  output logic                                 busy_o,
  output logic [IdxW-1:0]                      grant_idx_o,
  output logic                                 timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, READ} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [TransWidth-1:0] desc_q, desc_d;
  logic                  write_q, write_d;

  logic [IdxW-1:0]       win_idx;
  logic                  win_found;
  logic [IdxW-1:0]       cand;
  logic [NumPorts-1:0]   win_oh;
  logic [NumPorts-1:0]   grant_oh;
  logic                  abort_w;

  // Search starts one past the last winner so the previous owner goes last.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = IdxW'((int'(rr_q) + 1 + i) % NumPorts);
      if (!win_found && port_trans_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_onehot
    assign win_oh[gi]   = win_found && (win_idx == IdxW'(gi));
    assign grant_oh[gi] = (grant_q == IdxW'(gi));
  end

  always_comb begin
    state_d            = state_q;
    rr_d               = rr_q;
    grant_d            = grant_q;
    desc_d             = desc_q;
    write_d            = write_q;
    port_trans_ready_o = '0;
    port_tx_ready_o    = '0;
    port_rx_data_o     = '0;
    port_rx_last_o     = 1'b0;
    port_rx_error_o    = 1'b0;
    port_rx_valid_o    = '0;
    port_b_error_o     = 1'b0;
    port_b_valid_o     = '0;
    phy_trans_valid_o  = 1'b0;
    phy_tx_o           = '0;
    phy_tx_valid_o     = 1'b0;
    phy_rx_ready_o     = 1'b0;
    phy_b_ready_o      = 1'b0;
    case (state_q)
      IDLE: begin
        // A ready seen during reset would be a handshake the arbiter then forgets.
        if (win_found && !rst_i) begin
          port_trans_ready_o = win_oh;
          desc_d             = port_trans_i[win_idx];
          write_d            = port_trans_write_i[win_idx];
          grant_d            = win_idx;
          rr_d               = win_idx;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        phy_trans_valid_o = 1'b1;
        if (phy_trans_ready_i) state_d = write_q ? WRITE : READ;
      end
      WRITE: begin
        if (abort_w) begin
          port_b_valid_o = grant_oh;
          port_b_error_o = 1'b1;
          if (port_b_ready_i[grant_q]) state_d = IDLE;
        end else begin
          phy_tx_o        = port_tx_i[grant_q];
          phy_tx_valid_o  = port_tx_valid_i[grant_q];
          port_tx_ready_o = grant_oh & {NumPorts{phy_tx_ready_i}};
          port_b_valid_o  = grant_oh & {NumPorts{phy_b_valid_i}};
          port_b_error_o  = phy_b_error_i;
          phy_b_ready_o   = port_b_ready_i[grant_q];
          if (phy_b_valid_i && port_b_ready_i[grant_q]) state_d = IDLE;
        end
      end
      READ: begin
        if (abort_w) begin
          port_rx_valid_o = grant_oh;
          port_rx_last_o  = 1'b1;
          port_rx_error_o = 1'b1;
          if (port_rx_ready_i[grant_q]) state_d = IDLE;
        end else begin
          port_rx_data_o  = phy_rx_data_i;
          port_rx_last_o  = phy_rx_last_i;
          port_rx_error_o = phy_rx_error_i;
          port_rx_valid_o = grant_oh & {NumPorts{phy_rx_valid_i}};
          phy_rx_ready_o  = port_rx_ready_i[grant_q];
          if (phy_rx_valid_i && port_rx_ready_i[grant_q] && phy_rx_last_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= IdxW'(NumPorts - 1);
      grant_q <= '0;
      desc_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      desc_q  <= desc_d;
      write_q <= write_d;
    end
  end

  assign phy_trans_o = desc_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = grant_q;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            timeout_q, timeout_d;
  logic            phy_hs;

  assign phy_hs = (phy_tx_valid_o && phy_tx_ready_i) || (phy_rx_valid_i && phy_rx_ready_o) ||
                  (phy_b_valid_i && phy_b_ready_o);

  // Clearing during ISSUE means every WRITE/READ phase starts from zero.
  always_comb begin
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    timeout_d = 1'b0;
    if (state_q == ISSUE || state_q == IDLE) begin
      cnt_d   = '0;
      abort_d = 1'b0;
    end else if (!abort_q) begin
      if (phy_hs) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          abort_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign abort_w   = abort_q;
  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TimeoutCycles > 0);
  assign abort_w    = 1'b0;
  assign timeout_o  = 1'b0;
`endif

endmodule
